// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder controller.
// State encoding for the sequencing FSM.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// Single-bit full adder cell shared across all bit
// positions by the serial controller.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full_adder, LSB first,
// valid/ready on both operand and result sides.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fa_s, fa_c;

  full_adder u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (c_q),
    .s    (fa_s),
    .cout (fa_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = RUN;
          a_d     = a;
          b_d     = b;
          c_d     = cin;
          cnt_d   = '0;
          sum_d   = '0;
        end
      end
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        // Sum fills from the top so bit 0 lands last.
        sum_d = sum_q >> 1;
        sum_d[WIDTH-1] = fa_s;
        c_d   = fa_c;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = c_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench: WIDTH=8 scenarios plus an exhaustive
// WIDTH=2 instance sharing clock and reset.
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready;
  logic [7:0] a, b;
  logic       cin;
  logic       out_valid, out_ready;
  logic [7:0] sum;
  logic       cout, busy;

  logic       iv2, ir2;
  logic [1:0] a2, b2;
  logic       c2;
  logic       ov2, or2;
  logic [1:0] s2;
  logic       co2, bz2;

  int vec  = 0;
  int miss = 0;
  int cyc  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  serial_adder_ctrl #(.WIDTH(2)) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv2),
    .in_ready  (ir2),
    .a         (a2),
    .b         (b2),
    .cin       (c2),
    .out_valid (ov2),
    .out_ready (or2),
    .sum       (s2),
    .cout      (co2),
    .busy      (bz2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic add8(input string tag,
                      input logic [7:0] ta,
                      input logic [7:0] tb,
                      input logic tc,
                      input logic [7:0] es,
                      input logic ec);
    int n;
    int nb;
    @(negedge clk);
    chk({tag, " in_ready"}, in_ready, 1);
    in_valid  = 1'b1;
    a         = ta;
    b         = tb;
    cin       = tc;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n  = 0;
    nb = 0;
    while (!out_valid && n < 40) begin
      if (busy) nb++;
      @(negedge clk);
      n++;
    end
    chk({tag, " latency"}, n, 8);
    chk({tag, " busy_cycles"}, nb, 8);
    chk({tag, " sum"}, sum, es);
    chk({tag, " cout"}, cout, ec);
    chk({tag, " busy_done"}, busy, 0);
    @(negedge clk);
    chk({tag, " ov_after"}, out_valid, 0);
    chk({tag, " idle_after"}, in_ready, 1);
  endtask

  initial begin
    logic [7:0] va[4];
    logic [7:0] vb[4];
    logic       vc[4];
    logic [7:0] vs[4];
    logic       vo[4];
    int         t[4];
    int         n;
    logic [2:0] e2;

    va = '{8'h7F, 8'hC3, 8'h00, 8'hA5};
    vb = '{8'h01, 8'h3D, 8'h00, 8'h5A};
    vc = '{1'b0, 1'b1, 1'b1, 1'b0};
    vs = '{8'h80, 8'h01, 8'h01, 8'hFF};
    vo = '{1'b0, 1'b1, 1'b0, 1'b0};

    rst_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
    out_ready = 1'b0;
    iv2 = 1'b0; a2 = '0; b2 = '0; c2 = 1'b0; or2 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst in_ready", in_ready, 1);
    chk("rst out_valid", out_valid, 0);
    chk("rst busy", busy, 0);
    chk("rst sum", sum, 0);
    chk("rst cout", cout, 0);
    rst_n = 1'b1;

    add8("basic", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
    add8("ripple1", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    add8("ripple2", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1);
    add8("ripple3", 8'h80, 8'h80, 1'b1, 8'h01, 1'b1);

    // Backpressure with in_valid held high
    @(negedge clk);
    in_valid = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b0;
    out_ready = 1'b0;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 40) begin
      a = a + 8'd1;
      @(negedge clk);
      n++;
    end
    chk("bp latency", n, 8);
    for (int k = 0; k < 5; k++) begin
      chk("bp out_valid", out_valid, 1);
      chk("bp sum", sum, 8'h46);
      chk("bp cout", cout, 0);
      chk("bp in_ready", in_ready, 0);
      a = a + 8'd1;
      @(negedge clk);
    end
    out_ready = 1'b1;
    a = 8'h01; b = 8'h01; cin = 1'b0;
    @(negedge clk);
    chk("bp hs ov", out_valid, 0);
    chk("bp hs in_ready", in_ready, 1);
    chk("bp hs busy", busy, 0);
    @(negedge clk);
    chk("bp accept busy", busy, 1);
    chk("bp accept in_ready", in_ready, 0);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("bp2 sum", sum, 8'h02);
    chk("bp2 cout", cout, 0);
    @(negedge clk);

    // Reset in the middle of RUN
    @(negedge clk);
    in_valid = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid busy", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid in_ready", in_ready, 1);
    chk("mid out_valid", out_valid, 0);
    chk("mid sum", sum, 0);
    chk("mid busy0", busy, 0);
    repeat (10) begin
      @(negedge clk);
      chk("mid no_ov", out_valid, 0);
    end
    add8("post_rst", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);

    // Back-to-back with in_valid/out_ready held
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b1;
    a = va[0]; b = vb[0]; cin = vc[0];
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      t[k] = cyc;
      if (k > 0) chk("b2b spacing", t[k] - t[k-1], 10);
      n = 0;
      while (!out_valid && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk("b2b latency", n, 8);
      chk("b2b sum", sum, vs[k]);
      chk("b2b cout", cout, vo[k]);
      if (k < 3) begin
        a = va[k+1]; b = vb[k+1]; cin = vc[k+1];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      chk("b2b idle", in_ready, 1);
    end

    // Exhaustive WIDTH=2
    for (int ia = 0; ia < 4; ia++) begin
      for (int ib = 0; ib < 4; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          @(negedge clk);
          chk("w2 in_ready", ir2, 1);
          iv2 = 1'b1;
          a2  = 2'(ia);
          b2  = 2'(ib);
          c2  = 1'(ic);
          or2 = 1'b1;
          @(negedge clk);
          iv2 = 1'b0;
          n = 0;
          while (!ov2 && n < 20) begin
            @(negedge clk);
            n++;
          end
          e2 = 3'(ia + ib + ic);
          chk("w2 latency", n, 2);
          chk("w2 result", {co2, s2}, e2);
          @(negedge clk);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vec, miss);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial addition controller that time-shares one existing `full_adder` cell across a WIDTH-bit addition. It accepts one operand pair through a valid/ready handshake and feeds the cell one bit per cycle, LSB first, while holding the carry in a register. It assembles the sum and presents sum and carry-out through a second valid/ready handshake. It is the sequencing layer between a requester and the single-bit adder datapath, trading WIDTH cycles of latency for one full-adder instance.

## Interface
Parameters:
- `WIDTH`, default 8: operand and sum width; legal range WIDTH ≥ 1.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  operand pair offered.
- `in_ready`  out  1  controller can accept an operand pair.
- `a`  in  WIDTH  operand A, sampled on accept.
- `b`  in  WIDTH  operand B, sampled on accept.
- `cin`  in  1  carry-in, sampled on accept.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes the result.
- `sum`  out  WIDTH  (a + b + cin) mod 2^WIDTH.
- `cout`  out  1  carry-out of the MSB.
- `busy`  out  1  high in RUN.

## Operation
- States:
  - IDLE: `in_ready` = 1.
  - RUN: serial addition in progress.
  - DONE: `out_valid` = 1.
- IDLE → RUN on `in_valid && in_ready`. At that edge:
  - A shift register ← `a`.
  - B shift register ← `b`.
  - Carry register ← `cin`.
  - Bit counter ← 0.
  - Sum register ← 0.
- RUN, each cycle:
  - The full_adder inputs are A[0], B[0] and the carry register.
  - At the edge, A and B shift right by one.
  - The sum register shifts right with full_adder `s` entering at bit WIDTH-1.
  - Carry register ← full_adder `cout`.
  - Counter increments.
- RUN → DONE at the edge where counter == WIDTH-1, after the final bit has been processed.
- DONE:
  - `sum` and `cout` are driven from registers and stay stable until `out_valid && out_ready`.
  - On that handshake, DONE → IDLE.
- `in_ready` is high only in IDLE. `in_valid` is ignored in RUN and DONE, and operand inputs are not re-sampled.
- No output handshake and input accept occur in the same cycle. The next accept is possible the cycle after returning to IDLE.
- Counter width is $clog2(WIDTH+1). For WIDTH=1, RUN lasts exactly one cycle.
- Reset (`rst_n` = 0 at an edge), in any state including mid-RUN or DONE with pending output:
  - State ← IDLE; the in-flight operation is discarded.
  - Sum register, carry, counter and shift registers ← 0.
  - No `out_valid` is produced for the discarded operation.
- Reset values: `in_ready` = 1 (IDLE), `out_valid` = 0, `busy` = 0, `sum` = 0, `cout` = 0.

## Timing
- Accept at edge E. `busy` = 1 from after E through the edge E+WIDTH.
- `out_valid` rises after edge E+WIDTH, giving a latency of WIDTH cycles from accept to result visible.
- With `out_ready` held high, `out_valid` is high for exactly 1 cycle. IDLE follows after edge E+WIDTH+1, giving a peak throughput of one addition per WIDTH+2 cycles.
- `out_ready` low stalls DONE indefinitely. `sum` and `cout` do not change during the stall.
- All outputs are registered or decoded from registered state only. There is no combinational path from `in_valid` or `out_ready` to any output.

## Structure
- Package `serial_adder_pkg` holds the state enum typedef (IDLE, RUN, DONE).
- Exactly one sub-module: the existing `full_adder`, instantiated once, with ports `a`, `b`, `cin`, `s`, `cout` bound to A[0], B[0], the carry register, the serial sum bit and the next carry.
- All other logic is local: FSM, counter, shift registers and carry register.

## Test plan
All scenarios use WIDTH=8.
- Basic add: a=0x5A, b=0x3C, cin=0, single accept, out_ready high → `out_valid` exactly 8 cycles after accept, sum=0x96, cout=0; `busy` high for exactly 8 cycles.
- Carry ripple: a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then a=0xFF, b=0x00, cin=1 → sum=0x00, cout=1. Then a=0x80, b=0x80, cin=1 → sum=0x01, cout=1.
- Backpressure: a=0x12, b=0x34, out_ready low for 5 cycles after `out_valid` rises, with `in_valid` held high and a changing → sum=0x46 stable, `in_ready`=0 throughout, no second accept until the cycle after the output handshake.
- Reset mid-RUN: accept a=0xAA, b=0x55, deassert `rst_n` for one edge at bit 4 → next cycle IDLE, `in_ready`=1, `out_valid`=0, sum=0. A following add of 0x01+0x01 returns 0x02.
- Back-to-back: `in_valid` and `out_ready` held high, 4 random operand pairs → each accept spaced WIDTH+2 cycles apart, every result matches (a+b+cin) mod 256 with the correct cout.
- Exhaustive check at WIDTH=2 (separate elaboration): all 32 combinations of a, b, cin → results match the reference sum, latency 2 cycles.
